// File: rtl/subinst_sched_pkg.sv
// Shared types, constants and the round-robin pick function for subinst_rr_scheduler.
package subinst_sched_pkg;

    typedef enum logic {IDLE, BUSY} state_e;

    localparam int unsigned HOLD_W = 16;
    localparam int unsigned MAX_N  = 16;
    localparam int unsigned PICK_W = 4;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
    } pick_t;

    // First set bit of req scanning ptr, ptr+1, ... wrapping modulo n (n <= MAX_N, ptr < n).
    function automatic pick_t rr_pick(input logic [MAX_N-1:0]  req,
                                      input logic [PICK_W-1:0] ptr,
                                      input int unsigned       n);
        pick_t       res;
        logic [PICK_W:0] pos;
        res = '0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            pos = {1'b0, ptr} + (PICK_W+1)'(k);
            if (pos >= (PICK_W+1)'(n)) pos = pos - (PICK_W+1)'(n);
            if (k < n && !res.found && req[pos[PICK_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[PICK_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/subinst_rr_picker.sv
// Combinational rotate/priority-encode over N_REQ requesters starting at ptr_i, with wrap.
module subinst_rr_picker
    import subinst_sched_pkg::*;
#(
    parameter int unsigned N_REQ = 5,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [MAX_N-1:0]  req_ext;
    logic [PICK_W-1:0] ptr_ext;
    pick_t             pick;
    logic              unused_idx;

    always_comb begin
        req_ext               = '0;
        req_ext[N_REQ-1:0]    = req_i;
        ptr_ext               = '0;
        ptr_ext[IDX_W-1:0]    = ptr_i;
    end

    assign pick       = rr_pick(req_ext, ptr_ext, N_REQ);
    assign found_o    = pick.found;
    assign idx_o      = pick.idx[IDX_W-1:0];
    assign unused_idx = ^pick.idx;

endmodule

// File: rtl/subinst_rr_scheduler.sv
// Round-robin grant scheduler for N_REQ sibling sub-instances sharing one resource.
// Optional grant watchdog enabled by defining SUBINST_RR_TIMEOUT_EN.
module subinst_rr_scheduler
    import subinst_sched_pkg::*;
#(
    parameter int unsigned N_REQ    = 5,
    parameter int unsigned MAX_HOLD = 64,
    localparam int unsigned IDX_W   = $clog2(N_REQ)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_REQ-1:0]  req_i,
    input  logic [N_REQ-1:0]  done_i,
    output logic [N_REQ-1:0]  gnt_o,
    output logic [IDX_W-1:0]  gnt_id_o,
    output logic              busy_o,
    output logic [HOLD_W-1:0] hold_cnt_o,
    output logic              timeout_o
);

    state_e            state_q;
    logic [IDX_W-1:0]  ptr_q, gnt_id_q, pick_idx, nxt_ptr;
    logic [N_REQ-1:0]  gnt_q, pick_onehot;
    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q, pick_found, release_done, wd_expire;

    subinst_rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .found_o(pick_found),
        .idx_o  (pick_idx)
    );

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    assign nxt_ptr      = (gnt_id_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
    assign release_done = done_i[gnt_id_q];

`ifdef SUBINST_RR_TIMEOUT_EN
    assign wd_expire = (hold_q == HOLD_W'(MAX_HOLD - 1));
`else
    logic unused_max_hold;
    assign wd_expire       = 1'b0;
    assign unused_max_hold = ^MAX_HOLD;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q    <= pick_onehot;
                        gnt_id_q <= pick_idx;
                        hold_q   <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    // A done pulse on the limit cycle wins over the watchdog.
                    if (release_done || wd_expire) begin
                        gnt_q     <= '0;
                        hold_q    <= '0;
                        ptr_q     <= nxt_ptr;
                        state_q   <= IDLE;
                        timeout_q <= ~release_done;
                    end else if (hold_q != '1) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt_o      = gnt_q;
    assign gnt_id_o   = gnt_id_q;
    assign busy_o     = (state_q == BUSY);
    assign hold_cnt_o = hold_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_subinst_rr_scheduler.sv
// Scoreboard bench for subinst_rr_scheduler: directed cases plus randomized traffic.
module tb_subinst_rr_scheduler;

    localparam int unsigned N  = 5;
    localparam int unsigned MH = 8;
    localparam int unsigned IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req, done, gnt;
    logic [IW-1:0] gnt_id;
    logic          busy, timeout;
    logic [15:0]   hold_cnt;

    subinst_rr_scheduler #(
        .N_REQ   (N),
        .MAX_HOLD(MH)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .done_i    (done),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .busy_o    (busy),
        .hold_cnt_o(hold_cnt),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned  cyc;
        logic [N-1:0] gnt;
        int           id;
        logic         busy;
        int           hold;
        logic         tmo;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          nvec = 0;
    int          nerr = 0;

    // Reference model state: who holds the resource, for how long, where the scan starts.
    bit m_busy = 0;
    int m_id = 0, m_ptr = 0, m_hold = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic model_reset();
        m_busy = 0; m_id = 0; m_ptr = 0; m_hold = 0;
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
        exp_t e;
        bit   tmo;
        @(posedge clk);
        #1;
        req  = r;
        done = d;
        tmo  = 0;
        if (m_busy) begin
            if (d[m_id]) begin
                m_busy = 0; m_hold = 0; m_ptr = (m_id + 1) % N;
`ifdef SUBINST_RR_TIMEOUT_EN
            end else if (m_hold == MH - 1) begin
                m_busy = 0; m_hold = 0; m_ptr = (m_id + 1) % N; tmo = 1;
`endif
            end else if (m_hold < 65535) begin
                m_hold++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!m_busy && r[(m_ptr + k) % N]) begin
                    m_busy = 1; m_id = (m_ptr + k) % N; m_hold = 0;
                end
            end
        end
        e.cyc  = cyc + 1;
        e.gnt  = m_busy ? N'(1) << m_id : '0;
        e.id   = m_id;
        e.busy = m_busy;
        e.hold = m_hold;
        e.tmo  = tmo;
        sb.push_back(e);
    endtask

    // Drive req pattern r for n cycles; the grantee releases after holding `len` cycles.
    task automatic auto_run(input int n, input logic [N-1:0] r, input int len);
        logic [N-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = '0;
            if (m_busy && m_hold == len - 1) d[m_id] = 1'b1;
            step(r, d);
        end
    endtask

    task automatic check_reset(input string name);
        nvec++;
        if (gnt !== '0 || gnt_id !== '0 || busy !== 1'b0 || hold_cnt !== '0 || timeout !== 1'b0) begin
            nerr++;
            $display("FAIL %s: gnt=%b id=%0d busy=%b hold=%0d tmo=%b, expected all zero",
                     name, gnt, gnt_id, busy, hold_cnt, timeout);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset("async_reset_mid_busy");
        sb.delete();
        req  = '0;
        done = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compare every expected record when its cycle comes up.
    initial forever begin
        exp_t e;
        bit   ok;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            nvec++;
            ok = (e.cyc == cyc) && gnt === e.gnt && busy === e.busy && timeout === e.tmo &&
                 hold_cnt === 16'(e.hold) && (!e.busy || gnt_id === IW'(e.id));
            if (!ok) begin
                nerr++;
                $display("FAIL cycle %0d: gnt=%b id=%0d busy=%b hold=%0d tmo=%b, expected gnt=%b id=%0d busy=%b hold=%0d tmo=%b",
                         cyc, gnt, gnt_id, busy, hold_cnt, timeout,
                         e.gnt, e.id, e.busy, e.hold, e.tmo);
            end
        end
    end

    initial begin
        logic [N-1:0] r, d;
        rst  = 1'b1;
        req  = '0;
        done = '0;
        #3;
        check_reset("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester, release, then ptr must sit at 3.
        step(5'b00100, '0);
        step('0, '0);
        step('0, '0);
        step('0, 5'b00100);
        step('0, '0);
        step(5'b11111, '0);
        step('0, '0);
        step('0, 5'b01000);
        // Grant at 4, then wrap to 0.
        step(5'b10001, '0);
        step(5'b10001, '0);
        step(5'b10001, 5'b10000);
        step(5'b10001, '0);
        step('0, 5'b00001);
        // Foreign done and dropped req while gnt_id=1.
        step(5'b00010, '0);
        step('0, 5'b01000);
        step('0, '0);
        step('0, 5'b01101);
        step('0, 5'b00010);
        step('0, '0);

        async_reset();
        check_reset("reset_after_sequence");
        auto_run(24, 5'b11111, 3);
        auto_run(6, '0, 1);
        step(5'b01000, '0);
        for (int i = 0; i < 10; i++) step('0, '0);
        async_reset();
        step(5'b01000, '0);
        step('0, '0);
        step('0, 5'b01000);

        for (int i = 0; i < 3000; i++) begin
            r = N'($urandom);
            d = N'($urandom & $urandom & $urandom);
            if (m_busy) d[m_id] = ($urandom_range(5) == 0);
            step(r, d);
        end
        auto_run(12, '0, 1);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
